// File: rtl/kmeans_pkg.sv
// Shared k-means widths, the update-controller state encoding and the
// single-lane coordinate saturation helper.
package kmeans_pkg;

  localparam int centroid_num     = 8;
  localparam int lane_num         = 7;
  localparam int accum_cord_width = 22;
  localparam int cordinate_width  = 13;
  localparam int count_width      = 10;
  localparam int accum_width      = lane_num * accum_cord_width;
  localparam int data_width       = lane_num * cordinate_width;
  localparam int idx_width        = $clog2(centroid_num);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    LD   = 3'd2,
    DIV  = 3'd3,
    WR   = 3'd4,
    DONE = 3'd5
  } state_e;

  // Largest positive coordinate; its bitwise inverse is the most negative one.
  localparam logic signed [accum_cord_width-1:0] sat_max =
    accum_cord_width'((1 << (cordinate_width - 1)) - 1);
  localparam logic signed [accum_cord_width-1:0] sat_min = ~sat_max;

  function automatic logic [cordinate_width-1:0] sat_lane(
    input logic signed [accum_cord_width-1:0] v
  );
    logic signed [accum_cord_width-1:0] r;
    if (v > sat_max)      r = sat_max;
    else if (v < sat_min) r = sat_min;
    else                  r = v;
    return r[cordinate_width-1:0];
  endfunction

endpackage

// File: rtl/coord_sat_pack.sv
// Saturates seven signed divider quotients to centroid coordinates and packs
// them into one centroid word, lane 1 in the least significant bits.
module coord_sat_pack
  import kmeans_pkg::*;
(
  input  logic [accum_width-1:0] div_result,
  output logic [data_width-1:0]  cent_word
);

  always_comb begin
    cent_word = '0;
    for (int k = 0; k < lane_num; k++) begin
      cent_word[k*cordinate_width +: cordinate_width] =
        sat_lane(div_result[k*accum_cord_width +: accum_cord_width]);
    end
  end

endmodule

// File: rtl/centroid_update_ctrl.sv
// Walks every cluster at the end of a k-means iteration: read sums/count,
// divide, saturate, write the new centroid, clear the accumulator, flag motion.
//
// Handshake: start is a single-cycle request honoured only in IDLE; busy is
// high from the next cycle through the done cycle; done is a one-cycle pulse
// and converged is valid with done and held until the next accepted start.
module centroid_update_ctrl
  import kmeans_pkg::*;
#(
  parameter int                   addrWidth = 8,
  parameter int                   div_lat   = 1,
  parameter logic [addrWidth-1:0] acc_base  = '0,
  parameter logic [addrWidth-1:0] cent_base = '0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  output logic                               busy,
  output logic                               done,
  output logic                               converged,
  output logic                               acc_rd_en,
  output logic [addrWidth-1:0]               acc_rd_addr,
  input  logic [accum_width+count_width-1:0] acc_rd_data,
  output logic                               cent_rd_en,
  output logic [addrWidth-1:0]               cent_rd_addr,
  input  logic [data_width-1:0]              cent_rd_data,
  output logic [accum_width-1:0]             div_accum,
  output logic [count_width-1:0]             div_counter,
  input  logic [accum_width-1:0]             div_result,
  output logic                               cent_wr_en,
  output logic [addrWidth-1:0]               cent_wr_addr,
  output logic [data_width-1:0]              cent_wr_data,
  output logic                               acc_clr_en,
  output logic [addrWidth-1:0]               acc_clr_addr,
  output state_e                             state_dbg
);

  localparam int wait_width = (div_lat > 1) ? $clog2(div_lat + 1) : 1;
  localparam logic [idx_width-1:0] last_idx = idx_width'(centroid_num - 1);

  state_e                  state_q, state_d;
  logic [idx_width-1:0]    i_q;
  logic [wait_width-1:0]   wait_q;
  logic [data_width-1:0]   old_cent_q;
  logic [data_width-1:0]   new_word;
  logic                    changed_q;
  logic                    changed_next;
  logic                    cluster_valid;

  coord_sat_pack u_sat_pack (
    .div_result (div_result),
    .cent_word  (new_word)
  );

  // Empty clusters keep their old centroid and never count as movement.
  assign cluster_valid = (div_counter != '0);
  assign changed_next  = changed_q | (cluster_valid && (new_word != old_cent_q));
  assign state_dbg     = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      i_q         <= '0;
      wait_q      <= '0;
      div_accum   <= '0;
      div_counter <= '0;
      old_cent_q  <= '0;
      changed_q   <= 1'b0;
      converged   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            i_q       <= '0;
            changed_q <= 1'b0;
            converged <= 1'b0;
          end
        end
        LD: begin
          div_accum   <= acc_rd_data[accum_width-1:0];
          div_counter <= acc_rd_data[accum_width +: count_width];
          old_cent_q  <= cent_rd_data;
          wait_q      <= wait_width'(div_lat);
        end
        DIV: wait_q <= wait_q - wait_width'(1);
        WR: begin
          changed_q <= changed_next;
          if (i_q == last_idx) converged <= ~changed_next;
          else                 i_q       <= i_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    busy         = (state_q != IDLE);
    done         = 1'b0;
    acc_rd_en    = 1'b0;
    acc_rd_addr  = '0;
    cent_rd_en   = 1'b0;
    cent_rd_addr = '0;
    cent_wr_en   = 1'b0;
    cent_wr_addr = '0;
    cent_wr_data = '0;
    acc_clr_en   = 1'b0;
    acc_clr_addr = '0;
    case (state_q)
      IDLE: if (start) state_d = RD;
      RD: begin
        acc_rd_en    = 1'b1;
        acc_rd_addr  = acc_base + addrWidth'(i_q);
        cent_rd_en   = 1'b1;
        cent_rd_addr = cent_base + addrWidth'(i_q);
        state_d      = LD;
      end
      LD: state_d = DIV;
      DIV: if (wait_q <= wait_width'(1)) state_d = WR;
      WR: begin
        acc_clr_en   = 1'b1;
        acc_clr_addr = acc_base + addrWidth'(i_q);
        if (cluster_valid) begin
          cent_wr_en   = 1'b1;
          cent_wr_addr = cent_base + addrWidth'(i_q);
          cent_wr_data = new_word;
        end
        state_d = (i_q == last_idx) ? DONE : RD;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
